// File: rtl/dice_tid_dispatcher.sv
// dice_tid_dispatcher: walks linear thread ids 0..max_tid for one CTA and
// hands them to the CGRA subsystem over a valid/ready handshake, together
// with the x/y/z decomposition of each id.
// Optional feature macro: DICE_DISP_SKIP_MASK_EN adds the skip_mask port;
// a skipped tid costs one cycle with tid_valid low and is not counted.
//
// state | meaning
// IDLE  | waiting for start; a start with an out-of-range max_tid pulses cfg_err
// RUN   | sweeping; the cursor advances on handshake or on a skipped tid
// DONE  | sweep finished, done held until clr or start
module dice_tid_dispatcher #(
  parameter int NUM_TID   = 512,
  parameter int TID_WIDTH = $clog2(NUM_TID),
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clr,
  input  logic [TID_WIDTH-1:0] ntid_x,
  input  logic [TID_WIDTH-1:0] ntid_y,
  input  logic [TID_WIDTH-1:0] ntid_z,
  input  logic [TID_WIDTH-1:0] max_tid,
`ifdef DICE_DISP_SKIP_MASK_EN
  input  logic [NUM_TID-1:0]   skip_mask,
`endif
  output logic                 tid_valid,
  input  logic                 tid_ready,
  output logic [TID_WIDTH-1:0] dispatch_tid,
  output logic [TID_WIDTH-1:0] tid_x,
  output logic [TID_WIDTH-1:0] tid_y,
  output logic [TID_WIDTH-1:0] tid_z,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [CNT_WIDTH-1:0] disp_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int PW = 3 * (TID_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [TID_WIDTH-1:0] lin_q, lin_d;
  logic [TID_WIDTH-1:0] x_q, x_d;
  logic [TID_WIDTH-1:0] y_q, y_d;
  logic [TID_WIDTH-1:0] z_q, z_d;
  logic [TID_WIDTH-1:0] nx_q, nx_d;
  logic [TID_WIDTH-1:0] ny_q, ny_d;
  logic [TID_WIDTH-1:0] nz_q, nz_d;
  logic [TID_WIDTH-1:0] max_q, max_d;
  logic [CNT_WIDTH-1:0] disp_q, disp_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  logic [TID_WIDTH:0]   ext_x, ext_y, ext_z;
  logic [PW-1:0]        tid_total;
  logic                 cfg_legal;
  logic [TID_WIDTH-1:0] lin_inc;
  logic                 skip_first;
  logic                 skip_next;

  // Legality is judged once, on the start cycle, so a full product is fine
  // here; the cursor itself never multiplies or divides.
  assign ext_x     = {1'b0, ntid_x} + {{TID_WIDTH{1'b0}}, 1'b1};
  assign ext_y     = {1'b0, ntid_y} + {{TID_WIDTH{1'b0}}, 1'b1};
  assign ext_z     = {1'b0, ntid_z} + {{TID_WIDTH{1'b0}}, 1'b1};
  assign tid_total = PW'(ext_x) * PW'(ext_y) * PW'(ext_z);
  assign cfg_legal = PW'(max_tid) < tid_total;
  assign lin_inc   = lin_q + TID_WIDTH'(1);

`ifdef DICE_DISP_SKIP_MASK_EN
  logic [NUM_TID-1:0] skip_q, skip_d;
  assign skip_first = skip_mask[0];
  assign skip_next  = skip_q[lin_inc];
`else
  assign skip_first = 1'b0;
  assign skip_next  = 1'b0;
`endif

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Next-state, cursor and counter logic; clr overrides everything else.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    done_d    = done_q;
    cfg_err_d = 1'b0;
    lin_d     = lin_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
    nz_d      = nz_q;
    max_d     = max_q;
    disp_d    = disp_q;
    stall_d   = stall_q;
`ifdef DICE_DISP_SKIP_MASK_EN
    skip_d    = skip_q;
`endif

    if (clr) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (cfg_legal) begin
              state_d = ST_RUN;
              nx_d    = ntid_x;
              ny_d    = ntid_y;
              nz_d    = ntid_z;
              max_d   = max_tid;
`ifdef DICE_DISP_SKIP_MASK_EN
              skip_d  = skip_mask;
`endif
              lin_d   = '0;
              x_d     = '0;
              y_d     = '0;
              z_d     = '0;
              disp_d  = '0;
              stall_d = '0;
              done_d  = 1'b0;
              valid_d = ~skip_first;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (valid_q && !tid_ready) stall_d = sat_inc(stall_q);
          if (valid_q && tid_ready)  disp_d  = sat_inc(disp_q);
          // tid_valid low in RUN only ever means the current tid is skipped
          if (!valid_q || tid_ready) begin
            if (lin_q == max_q) begin
              state_d = ST_DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              lin_d   = lin_inc;
              valid_d = ~skip_next;
              if (x_q == nx_q) begin
                x_d = '0;
                if (y_q == ny_q) begin
                  y_d = '0;
                  z_d = z_q + TID_WIDTH'(1);
                end else begin
                  y_d = y_q + TID_WIDTH'(1);
                end
              end else begin
                x_d = x_q + TID_WIDTH'(1);
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  // State, cursor, captured configuration and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      lin_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
      nz_q      <= '0;
      max_q     <= '0;
      disp_q    <= '0;
      stall_q   <= '0;
`ifdef DICE_DISP_SKIP_MASK_EN
      skip_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      lin_q     <= lin_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      nz_q      <= nz_d;
      max_q     <= max_d;
      disp_q    <= disp_d;
      stall_q   <= stall_d;
`ifdef DICE_DISP_SKIP_MASK_EN
      skip_q    <= skip_d;
`endif
    end
  end

  assign tid_valid    = valid_q;
  assign dispatch_tid = lin_q;
  assign tid_x        = x_q;
  assign tid_y        = y_q;
  assign tid_z        = z_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign disp_count   = disp_q;
  assign stall_count  = stall_q;

endmodule

// File: doc/dice_tid_dispatcher.md
DICE_TID_DISPATCHER -- requirements
Module: dice_tid_dispatcher

Interface
REQ-001 SHALL have parameter NUM_TID, default 512, meaning maximum threads per CTA; power of two, 2..4096.
REQ-002 SHALL have derived parameter TID_WIDTH, default $clog2(NUM_TID), meaning width of every thread-index field.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, meaning width of the performance counters.
REQ-004 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a dispatch sweep.
- clr  in  1  synchronous abort; returns to IDLE.
- ntid_x, ntid_y, ntid_z  in  TID_WIDTH each  last index per dimension (extent-1).
- max_tid  in  TID_WIDTH  last linear tid to dispatch.
- skip_mask  in  NUM_TID  bit t=1 skips tid t (present only with DICE_DISP_SKIP_MASK_EN).
- tid_valid  out  1  payload valid.
- tid_ready  in  1  consumer (CGRA subsystem) accepts.
- dispatch_tid  out  TID_WIDTH  linear tid.
- tid_x, tid_y, tid_z  out  TID_WIDTH each  3D decomposition of dispatch_tid.
- busy  out  1  state is RUN.
- done  out  1  sweep complete, held until clr or start.
- cfg_err  out  1  start rejected: max_tid > (ntid_x+1)(ntid_y+1)(ntid_z+1)-1.
- disp_count  out  CNT_WIDTH  tids accepted this sweep.
- stall_count  out  CNT_WIDTH  cycles with tid_valid=1 and tid_ready=0 this sweep.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DONE.
REQ-006 SHALL transition IDLE->RUN on start when the configuration is legal; an illegal start SHALL set cfg_err for one cycle and remain in IDLE.
REQ-007 SHALL sample ntid_*, max_tid and skip_mask at start and ignore later changes during the sweep.
REQ-008 SHALL on start zero disp_count, stall_count, the linear cursor and the x/y/z cursors, and clear done.
REQ-009 SHALL register all outputs, so the first tid_valid appears one cycle after start.
REQ-010 SHALL advance the cursor when tid_valid&tid_ready, or when the current tid is skipped; x SHALL wrap from ntid_x to 0 and carry into y, y SHALL wrap from ntid_y and carry into z; no multiplier or divider is permitted.
REQ-011 SHALL hold dispatch_tid and tid_x/y/z stable while tid_valid=1 and tid_ready=0, and SHALL NOT deassert tid_valid until the handshake completes.
REQ-012 SHALL sustain one tid per cycle with tid_ready held high.
REQ-013 SHALL move RUN->DONE in the cycle after the handshake of tid max_tid, or after skipping max_tid; tid_valid=0 and done=1 in DONE.
REQ-014 SHALL give clr priority over start and over the handshake in any state: tid_valid=0, busy=0 and done=0 next cycle, with counters held.
REQ-015 SHALL restart a sweep on start received in DONE; start in RUN SHALL be ignored.
REQ-016 SHALL saturate the counters at all-ones.

Reset
REQ-017 SHALL on rst_n low asynchronously force IDLE and drive tid_valid, busy, done, cfg_err, dispatch_tid, tid_x/y/z, disp_count and stall_count to 0.
REQ-018 SHALL abandon an in-flight tid on reset mid-sweep, with no handshake.

Configuration
REQ-019 SHALL compile skip_mask and skip logic only when DICE_DISP_SKIP_MASK_EN is defined: a skipped tid consumes one cycle with tid_valid=0 and is not counted.
REQ-020 SHALL, without DICE_DISP_SKIP_MASK_EN, omit the skip_mask port and dispatch every tid 0..max_tid.

Verification
REQ-021 SHALL cover: ntid_x=255, ntid_y=ntid_z=0, max_tid=255, start, ready=1 -> tids 0..255 on consecutive cycles, done 257 cycles after start, disp_count=256, stall_count=0.
REQ-022 SHALL cover: ntid_x=3, ntid_y=1, ntid_z=1, max_tid=15 -> tid 5 shows (x,y,z)=(1,1,0), tid 13 shows (1,1,1), done after tid 15.
REQ-023 SHALL cover: ready low 3 cycles while tid 7 is valid -> tid 7 held stable, stall_count=3, no tid lost or duplicated.
REQ-024 SHALL cover: ntid all 0, max_tid=4, start -> cfg_err pulse, FSM stays IDLE, tid_valid never asserts.
REQ-025 SHALL cover: clr at tid 40, then start -> next sweep begins at tid 0 with counters zeroed; rst_n low at tid 10 -> all outputs 0 immediately.
REQ-026 SHALL cover, with the macro: skip_mask bits 2 and 3 set, max_tid=5 -> tids 0,1,4,5 dispatched, disp_count=4, done after tid 5.
